// File: rtl/sayac_mem_pkg.sv
// Shared types and default widths for the memory responder and the cache side.
package sayac_mem_pkg;
  localparam int DATA_W_DEF    = 16;
  localparam int ADR_W_DEF     = 16;
  localparam int MEM_ADR_W_DEF = 10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word array; read data register holds until the next read.
module mem_array #(
  parameter int DATA_WIDTH    = 16,
  parameter int MEM_ADR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic                     rzero,
  input  logic [MEM_ADR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);
  localparam int MEM_SIZE = 1 << MEM_ADR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // Storage is deliberately not reset.
  always_ff @(posedge clk)
    if (we) mem[index] <= wdata;

  always_ff @(posedge clk or negedge rst)
    if (!rst)    rdata <= '0;
    else if (re) rdata <= rzero ? '0 : mem[index];
endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: accepts one rd/wr at a time, inserts WAIT_CYCLES
// wait states, then pulses ready. Optional macro ADR_RANGE_CHECK_EN adds err.
module mem_responder
  import sayac_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int ADR_WIDTH     = ADR_W_DEF,
  parameter int MEM_ADR_WIDTH = MEM_ADR_W_DEF,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADR_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout,
  input  logic                  rd,
  input  logic                  wr,
  output logic                  ready
`ifdef ADR_RANGE_CHECK_EN
  ,
  output logic                  err
`endif
);
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q;
  op_t                      op_q, op_in, cur_op;
  logic [MEM_ADR_WIDTH-1:0] idx_q, cur_idx;
  logic [DATA_WIDTH-1:0]    wdat_q, cur_wdat;
  logic                     oor_q, oor_in, cur_oor;
  logic                     accept, enter_done, we, re;

`ifdef ADR_RANGE_CHECK_EN
  assign oor_in = |address[ADR_WIDTH-1:MEM_ADR_WIDTH];
`else
  // Upper bits alias into the array.
  logic unused_hi;
  assign unused_hi = ^address[ADR_WIDTH-1:MEM_ADR_WIDTH];
  assign oor_in    = 1'b0;
`endif

  assign op_in  = wr ? OP_WR : OP_RD;
  assign accept = (state_q == IDLE) && (rd ^ wr);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd ^ wr) state_d = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;

  always_ff @(posedge clk or negedge rst)
    if (!rst)                                  cnt_q <= 4'd0;
    else if (accept)                           cnt_q <= CNT_LOAD;
    else if (state_q == BUSY && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      op_q   <= OP_RD;
      idx_q  <= '0;
      wdat_q <= '0;
      oor_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= op_in;
      idx_q  <= address[MEM_ADR_WIDTH-1:0];
      wdat_q <= datain;
      oor_q  <= oor_in;
    end

  // With zero wait states the accept edge is also the commit edge, so the
  // array must see the live request rather than the not-yet-latched copy.
  always_comb begin
    cur_op   = op_q;
    cur_idx  = idx_q;
    cur_wdat = wdat_q;
    cur_oor  = oor_q;
    if (state_q == IDLE) begin
      cur_op   = op_in;
      cur_idx  = address[MEM_ADR_WIDTH-1:0];
      cur_wdat = datain;
      cur_oor  = oor_in;
    end
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);
  assign we         = enter_done && (cur_op == OP_WR) && !cur_oor;
  assign re         = enter_done && (cur_op == OP_RD);

  mem_array #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEM_ADR_WIDTH(MEM_ADR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .re   (re),
    .rzero(cur_oor),
    .index(cur_idx),
    .wdata(cur_wdat),
    .rdata(dataout)
  );

  assign ready = (state_q == DONE);
`ifdef ADR_RANGE_CHECK_EN
  assign err = ready && oor_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with 0.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address, datain, dataout, address_b, datain_b, dataout_b;
  logic        rd, wr, ready, rd_b, wr_b, ready_b;
`ifdef ADR_RANGE_CHECK_EN
  logic        err, err_b;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_WIDTH(16), .ADR_WIDTH(16), .MEM_ADR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .address(address), .datain(datain), .dataout(dataout),
    .rd(rd), .wr(wr), .ready(ready)
`ifdef ADR_RANGE_CHECK_EN
    , .err(err)
`endif
  );

  mem_responder #(.DATA_WIDTH(16), .ADR_WIDTH(16), .MEM_ADR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .address(address_b), .datain(datain_b), .dataout(dataout_b),
    .rd(rd_b), .wr(wr_b), .ready(ready_b)
`ifdef ADR_RANGE_CHECK_EN
    , .err(err_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full command; the command stays driven through the DONE->IDLE edge.
  task automatic op(input bit b, input bit w, input logic [15:0] a, input logic [15:0] d,
                    input string tag, input bit chk_rd, input logic [15:0] exp);
    int n;
    int lat;
    lat = b ? 0 : 2;
    @(negedge clk);
    if (b) begin address_b = a; datain_b = d; rd_b = !w; wr_b = w; end
    else   begin address   = a; datain   = d; rd   = !w; wr   = w; end
    @(posedge clk); #1;
    n = 0;
    while (!(b ? ready_b : ready) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    if (chk_rd) chk({tag, "_data"}, b ? dataout_b : dataout, exp);
`ifdef ADR_RANGE_CHECK_EN
    chk({tag, "_err"}, b ? err_b : err, (a >= 16'h0400) ? 1 : 0);
`endif
    @(posedge clk); #1;
    chk({tag, "_held"}, b ? ready_b : ready, 0);
    if (b) begin rd_b = 1'b0; wr_b = 1'b0; end
    else   begin rd   = 1'b0; wr   = 1'b0; end
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    address = '0; datain = '0; rd = 1'b0; wr = 1'b0;
    address_b = '0; datain_b = '0; rd_b = 1'b0; wr_b = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready_a", ready, 0);
    chk("rst_dout_a", dataout, 16'h0000);
    chk("rst_ready_b", ready_b, 0);
    chk("rst_dout_b", dataout_b, 16'h0000);
`ifdef ADR_RANGE_CHECK_EN
    chk("rst_err_a", err, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // write then read
    op(0, 1, 16'h0010, 16'h0751, "wr10", 0, 16'h0);
    op(0, 0, 16'h0010, 16'h0000, "rd10", 1, 16'h0751);

    // back-to-back with a NOP
    op(0, 1, 16'h0011, 16'h1111, "wr11", 0, 16'h0);
    op(0, 1, 16'h0012, 16'h2222, "wr12", 0, 16'h0);
    chk("wr_keeps_dout", dataout, 16'h0751);
    op(0, 0, 16'h0011, 16'h0000, "rd11", 1, 16'h1111);
    @(posedge clk); #1;
    chk("nop_ready", ready, 0);
    op(0, 0, 16'h0012, 16'h0000, "rd12", 1, 16'h2222);

    // rd=wr=1 is ignored for its whole duration
    @(negedge clk);
    address = 16'h0010; datain = 16'hFFFF; rd = 1'b1; wr = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    rd = 1'b0; wr = 1'b0;
    chk("illegal_ready", seen, 0);
    chk("illegal_dout", dataout, 16'h2222);
    op(0, 0, 16'h0010, 16'h0000, "rd10b", 1, 16'h0751);

    // reset while the write is waiting
    op(0, 1, 16'h0020, 16'h0BAD, "wr20", 0, 16'h0);
    @(negedge clk);
    address = 16'h0020; datain = 16'hBEEF; wr = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy_ready", ready, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("abort_rst_ready", ready, 0);
    chk("abort_rst_dout", dataout, 16'h0000);
    wr = 1'b0;
    @(negedge clk) rst = 1'b1;
    op(0, 0, 16'h0020, 16'h0000, "rd20", 1, 16'h0BAD);

    // zero wait states at the top word
    op(1, 1, 16'h03FF, 16'hA5A5, "b_wr3ff", 0, 16'h0);
    op(1, 0, 16'h03FF, 16'h0000, "b_rd3ff", 1, 16'hA5A5);

    // address beyond the array
    op(0, 1, 16'h0000, 16'h5555, "wr0", 0, 16'h0);
    op(0, 1, 16'h0400, 16'h1234, "wr400", 0, 16'h0);
`ifdef ADR_RANGE_CHECK_EN
    op(0, 0, 16'h0000, 16'h0000, "rd0", 1, 16'h5555);
    op(0, 0, 16'h0400, 16'h0000, "rd400", 1, 16'h0000);
`else
    op(0, 0, 16'h0000, 16'h0000, "rd0_alias", 1, 16'h1234);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
